// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the arbiter requester
package arb_pkg;

    localparam int ARB_NUM_PORTS_DFLT = 4;
    localparam int ARB_IDX_W          = $clog2(ARB_NUM_PORTS_DFLT);
    localparam int ARB_MAX_PORTS      = 32;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // True when exactly one bit of vec is set
    function automatic logic is_onehot(input logic [ARB_MAX_PORTS-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/arb_port_ctr.sv
// rtl/arb_port_ctr.sv - per-port saturating pending count and starvation timer
module arb_port_ctr
    import arb_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic accept,
    input  logic in_busy,
    output logic nonzero,
    output logic full,
    output logic starve
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [WAIT_W-1:0] wait_q;
    logic              acc;

    // Acceptance can only happen while the resource is free
    assign acc     = accept & ~in_busy;
    assign nonzero = (cnt != '0);
    assign full    = (cnt == {CNT_W{1'b1}});
    assign starve  = (wait_q == WAIT_MAX);

    // Push and accept in the same cycle cancel; a push into a full counter is dropped
    always_comb begin
        cnt_nxt = cnt;
        if (acc && !push)
            cnt_nxt = cnt - 1'b1;
        else if (push && !acc && !full)
            cnt_nxt = cnt + 1'b1;
    end

    // Pending count and wait timer; wait clears on service or once the port drains
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            wait_q <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (acc || (cnt_nxt == '0))
                wait_q <= '0;
            else if (nonzero && (wait_q != WAIT_MAX))
                wait_q <= wait_q + 1'b1;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - request side of the fixed-priority arbiter with burst hold
module arb_requester
    import arb_pkg::*;
#(
    parameter int NUM_PORTS    = ARB_NUM_PORTS_DFLT,
    parameter int CNT_W        = 4,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_PORTS-1:0]         push_i,
    output logic [NUM_PORTS-1:0]         full_o,
    output logic [NUM_PORTS-1:0]         req_o,
    input  logic [NUM_PORTS-1:0]         gnt_i,
    output logic                         serve_o,
    output logic [$clog2(NUM_PORTS)-1:0] serve_idx_o,
    output logic                         busy_o,
    output logic [NUM_PORTS-1:0]         starve_o,
    output logic                         err_o
);

    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_e           state;
    logic [BEAT_W-1:0]    beat;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_PORTS-1:0] nonzero;
    logic [NUM_PORTS-1:0] accept;
    logic                 gnt_valid;

    // One counter pair per client port
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        arb_port_ctr #(
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_ctr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push    (push_i[g]),
            .accept  (accept[g]),
            .in_busy (busy_o),
            .nonzero (nonzero[g]),
            .full    (full_o[g]),
            .starve  (starve_o[g])
        );
    end

    assign busy_o    = (state == ARB_BUSY);
    assign req_o     = busy_o ? '0 : nonzero;
    assign gnt_valid = !busy_o && is_onehot(ARB_MAX_PORTS'(gnt_i)) && ((gnt_i & ~req_o) == '0);
    assign accept    = gnt_valid ? gnt_i : '0;
    assign serve_o   = gnt_valid;

    // The served index is visible in the grant cycle and held from the register afterwards
    assign serve_idx_o = gnt_valid ? gnt_idx : idx_q;

    // Encode the one-hot grant into a port index
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (gnt_i[i])
                gnt_idx = i[IDX_W-1:0];
    end

    // IDLE/BUSY sequencing, burst beat counter and sticky protocol error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
            beat  <= '0;
            idx_q <= '0;
            err_o <= 1'b0;
        end else begin
            if ((gnt_i != '0) && !gnt_valid)
                err_o <= 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        idx_q <= gnt_idx;
                        beat  <= BEAT_W'(BURST_LEN - 1);
                        state <= ARB_BUSY;
                    end
                end
                default: begin
                    if (beat == '0)
                        state <= ARB_IDLE;
                    else
                        beat <= beat - 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/arb_requester.md
# arb_requester

Request-side companion to the fixed-priority combinational arbiter. Keeps a saturating per-port count of pending requests posted by clients, drives the arbiter's request vector, accepts the returned one-hot grant, and holds a shared resource for a fixed burst before re-arbitrating. Also flags starvation per port and protocol errors on the grant input. It sits between the client ports and the arbiter; `req_o`/`gnt_i` connect directly to the arbiter's `req_i`/`gnt_o`.

## Interface
- NUM_PORTS, 4, number of client ports; must be ≥ 2
- CNT_W, 4, pending-count width per port; saturates at 2^CNT_W−1
- BURST_LEN, 4, cycles the resource is held per grant; ≥ 1
- STARVE_LIMIT, 15, wait cycles before `starve_o[i]` asserts; ≥ 1

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- push_i  input  NUM_PORTS  per-port one-cycle request post
- full_o  output  NUM_PORTS  port counter saturated
- req_o  output  NUM_PORTS  request vector to arbiter
- gnt_i  input  NUM_PORTS  one-hot grant from arbiter, same cycle as `req_o`
- serve_o  output  1  one-cycle pulse when a grant is accepted
- serve_idx_o  output  $clog2(NUM_PORTS)  index of the granted port, held through BUSY
- busy_o  output  1  resource held (state BUSY)
- starve_o  output  NUM_PORTS  port waited ≥ STARVE_LIMIT cycles
- err_o  output  1  sticky grant-protocol error

## Operation
- Two-state FSM: IDLE, BUSY.
- IDLE: `req_o[i] = (cnt[i] != 0)`. The grant is valid when `gnt_i` is one-hot and `gnt_i & ~req_o == 0`.
- A valid grant in IDLE:
  - decrements `cnt[idx]`
  - registers `serve_idx_o = idx`
  - pulses `serve_o` (combinational, same cycle)
  - loads the beat counter with BURST_LEN−1
  - moves to BUSY
- BUSY:
  - `req_o = 0`, `busy_o = 1`
  - the beat counter decrements each cycle; at 0 the FSM returns to IDLE
  - BUSY lasts exactly BURST_LEN cycles
- Push handling:
  - `push_i[i]` increments `cnt[i]` in any state.
  - Push and accepted grant on the same port in the same cycle: count unchanged.
  - Push while full (and no grant on that port that cycle): dropped. `full_o[i] = (cnt[i] == max)`.
- Starvation:
  - `wait[i]` increments (saturating at STARVE_LIMIT) each cycle that `cnt[i] != 0` and port i is not accepted, in both IDLE and BUSY.
  - It clears on acceptance of port i, or when `cnt[i]` becomes 0.
  - `starve_o[i] = (wait[i] == STARVE_LIMIT)`.
- Errors:
  - `err_o` sets on any nonzero `gnt_i` that is not a valid grant (not one-hot, grants an unrequested port, or nonzero in BUSY).
  - An invalid grant is ignored: no state change.
  - `err_o` clears only on reset.

## Timing
- Reset (asynchronous, any cycle, including mid-BUSY):
  - state IDLE
  - all `cnt`, `wait` and beat counter cleared
  - `serve_idx_o = 0`, `err_o = 0`
  - hence `req_o`, `full_o`, `starve_o`, `busy_o`, `serve_o` all 0
  - pending pushes are lost
- Push-to-request latency: `push_i` at cycle n → `req_o` high at n+1 (if IDLE).
- Grant path: `req_o` → arbiter → `gnt_i` is combinational within one cycle. `serve_o` pulses that cycle; BUSY spans cycles n+1 … n+BURST_LEN.
- Back-to-back service: with work pending, `req_o` reasserts the cycle after BUSY ends. Minimum grant spacing is BURST_LEN+1 cycles.
- BURST_LEN = 1: single BUSY cycle.

## Structure
- Package `arb_pkg`:
  - `arb_state_e` enum (IDLE, BUSY)
  - function `is_onehot(vec)`
  - localparam for the index width
- Sub-module `arb_port_ctr`, instantiated NUM_PORTS times. Holds the saturating `cnt` and `wait` counters. Inputs: push, accept, in_busy. Outputs: nonzero, full, starve.
- Top-level holds the FSM, beat counter, grant validation and `err_o`.

## Test plan
- Reset, then `push_i = 4'b0100` for one cycle, with the fixed-priority arbiter attached. Required: `req_o = 4'b0100` next cycle, `serve_o` and `serve_idx_o = 2` that cycle, `busy_o` high for exactly 4 cycles, `req_o = 0` afterwards.
- Push port 0 three times and port 3 once (fixed-priority arbiter attached). Required: three port-0 services, then port 3. `starve_o[3]` rises after 15 waiting cycles and clears on port-3 service.
- Sixteen pushes on port 1 with no service (drive `gnt_i = 0`). Required: `full_o[1]` after the 15th push, the 16th is dropped, and exactly 15 services follow once grants resume.
- Simultaneous push and valid grant on port 2 with `cnt = 1`. Required: `cnt` stays 1 and `req_o[2]` reasserts after BUSY.
- Force `gnt_i = 4'b0011`, then `4'b1000` with `req_o[3] = 0`. Required: `err_o` sets and stays set, no `serve_o`, counts unchanged.
- Assert `rst_i` mid-BUSY with pending counts. Required: all outputs 0 immediately; after release, `req_o` stays 0 until new pushes.
